// File: rtl/id_decode.sv
// -----------------------------------------------------------------------------
// id_decode -- DLX instruction-decode stage with a registered output slice.
//
// Purpose
//   Decodes one 32-bit DLX instruction word per cycle into ALU opcode,
//   register indices, extended immediate and control enables. All decoded
//   outputs are registered, so there is one cycle from capture to out_valid.
//   A load-use hazard against the most recently emitted LW is detected
//   combinationally. The hazard inserts a single bubble.
//
// Handshake
//   The input side is valid-only. An instruction is captured on a rising edge
//   when in_valid=1, stall=0, flush=0 and hz_stall=0. While hz_stall=1, the
//   upstream stage must keep the same instr/in_valid so that it is captured on
//   the following edge. On the output side, out_valid=1 marks a real
//   instruction. stall=1 freezes every output register. This includes
//   out_valid and the load tracker.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : asynchronous, active-high
//   in_valid   : instr carries a valid word
//   instr      : DLX instruction word
//   stall      : downstream hold, outputs freeze
//   flush      : kill the instruction being captured
//   hz_stall   : load-use hazard, upstream must hold instr
//   out_valid  : registered outputs describe a real instruction
//   alu_op     : ALU opcode 0..17
//   rs1/rs2/rd : register indices
//   imm        : extended immediate
//   use_imm, reg_write, mem_read, mem_write, branch, jump, illegal : controls
// -----------------------------------------------------------------------------
module id_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        flush,
  output logic        hz_stall,
  output logic        out_valid,
  output logic [4:0]  alu_op,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        use_imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic        illegal
);

  // Instruction fields
  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [31:0] w_imm_s16;
  logic [31:0] w_imm_z16;
  logic [31:0] w_imm_s26;

  assign w_op      = instr[31:26];
  assign w_fn      = instr[5:0];
  assign w_imm_s16 = {{16{instr[15]}}, instr[15:0]};
  assign w_imm_z16 = {16'h0000, instr[15:0]};
  assign w_imm_s26 = {{6{instr[25]}}, instr[25:0]};

  // Combinational decode
  logic [4:0]  w_alu_op;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  logic        w_use_imm;
  logic        w_reg_write;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_branch;
  logic        w_jump;
  logic        w_illegal;
  logic        w_uses_rs2;
  logic        w_hz;

  always_comb begin
    w_alu_op    = 5'd1;
    w_rs1       = 5'd0;
    w_rs2       = 5'd0;
    w_rd        = 5'd0;
    w_imm       = 32'h0;
    w_use_imm   = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_illegal   = 1'b0;
    w_uses_rs2  = 1'b0;

    case (w_op)
      6'h00: begin
        w_rs1      = instr[25:21];
        w_rs2      = instr[20:16];
        w_rd       = instr[15:11];
        w_uses_rs2 = 1'b1;
        case (w_fn)
          6'h20:   w_alu_op = 5'd1;
          6'h22:   w_alu_op = 5'd2;
          6'h24:   w_alu_op = 5'd3;
          6'h25:   w_alu_op = 5'd4;
          6'h26:   w_alu_op = 5'd5;
          6'h04:   w_alu_op = 5'd6;
          6'h06:   w_alu_op = 5'd7;
          6'h28:   w_alu_op = 5'd10;
          6'h2C:   w_alu_op = 5'd11;
          6'h2A:   w_alu_op = 5'd12;
          6'h29:   w_alu_op = 5'd13;
          6'h07:   w_alu_op = 5'd14;
          default: w_illegal = 1'b1;
        endcase
        w_reg_write = !w_illegal;
      end
      // Immediate ALU ops. The logical ops zero-extend and the rest
      // sign-extend.
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h14, 6'h16,
      6'h18, 6'h1C, 6'h1A, 6'h19, 6'h17: begin
        w_rs1       = instr[25:21];
        w_rd        = instr[20:16];
        w_use_imm   = 1'b1;
        w_reg_write = 1'b1;
        w_imm       = w_imm_s16;
        case (w_op)
          6'h08:   w_alu_op = 5'd1;
          6'h0A:   w_alu_op = 5'd2;
          6'h0C:   begin w_alu_op = 5'd3; w_imm = w_imm_z16; end
          6'h0D:   begin w_alu_op = 5'd4; w_imm = w_imm_z16; end
          6'h0E:   begin w_alu_op = 5'd5; w_imm = w_imm_z16; end
          6'h14:   w_alu_op = 5'd6;
          6'h16:   w_alu_op = 5'd7;
          6'h18:   w_alu_op = 5'd10;
          6'h1C:   w_alu_op = 5'd11;
          6'h1A:   w_alu_op = 5'd12;
          6'h19:   w_alu_op = 5'd13;
          default: w_alu_op = 5'd14;
        endcase
      end
      6'h0F: begin // LHI
        w_alu_op    = 5'd0;
        w_rs1       = instr[25:21];
        w_rd        = instr[20:16];
        w_imm       = w_imm_z16;
        w_use_imm   = 1'b1;
        w_reg_write = 1'b1;
      end
      6'h23: begin // LW
        w_rs1       = instr[25:21];
        w_rd        = instr[20:16];
        w_imm       = w_imm_s16;
        w_use_imm   = 1'b1;
        w_reg_write = 1'b1;
        w_mem_read  = 1'b1;
      end
      6'h2B: begin // SW: the data register travels on rs2, nothing written back
        w_rs1       = instr[25:21];
        w_rs2       = instr[20:16];
        w_imm       = w_imm_s16;
        w_use_imm   = 1'b1;
        w_mem_write = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      6'h04, 6'h05: begin // BEQZ / BNEZ
        w_alu_op  = (w_op == 6'h04) ? 5'd16 : 5'd17;
        w_rs1     = instr[25:21];
        w_rd      = instr[20:16];
        w_imm     = w_imm_s16;
        w_use_imm = 1'b1;
        w_branch  = 1'b1;
      end
      // J / JAL use the 26-bit offset field. They read no register, so rs1
      // stays 0 and cannot raise a false load-use hazard.
      6'h02: begin
        w_imm     = w_imm_s26;
        w_use_imm = 1'b1;
        w_jump    = 1'b1;
      end
      6'h03: begin
        w_alu_op    = 5'd15;
        w_rd        = 5'd31;
        w_imm       = w_imm_s26;
        w_use_imm   = 1'b1;
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
      end
      6'h12: begin // JR
        w_rs1     = instr[25:21];
        w_rd      = instr[20:16];
        w_imm     = w_imm_s16;
        w_use_imm = 1'b1;
        w_jump    = 1'b1;
      end
      6'h13: begin // JALR
        w_alu_op    = 5'd15;
        w_rs1       = instr[25:21];
        w_rd        = 5'd31;
        w_imm       = w_imm_s16;
        w_use_imm   = 1'b1;
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase

    // r0 is hard-wired zero, so it is never a write target.
    if (w_rd == 5'd0) w_reg_write = 1'b0;
  end

  // Load tracker and output registers
  logic        r_out_valid;
  logic [4:0]  r_alu_op;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [31:0] r_imm;
  logic        r_use_imm;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_branch;
  logic        r_jump;
  logic        r_illegal;
  logic [4:0]  r_ld_rd;
  logic        r_ld_valid;

  assign w_hz = in_valid && r_ld_valid && (r_ld_rd != 5'd0) &&
                ((r_ld_rd == w_rs1) || (w_uses_rs2 && (r_ld_rd == w_rs2)));

  // Stall wins over everything. Flush, hazard bubble and idle all load an
  // empty slot. The bubble clears the tracker, which is why the hazard lasts
  // exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_alu_op    <= 5'd0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_imm       <= 32'h0;
      r_use_imm   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_illegal   <= 1'b0;
      r_ld_rd     <= 5'd0;
      r_ld_valid  <= 1'b0;
    end else if (!stall) begin
      if (in_valid && !flush && !w_hz) begin
        r_out_valid <= 1'b1;
        r_alu_op    <= w_alu_op;
        r_rs1       <= w_rs1;
        r_rs2       <= w_rs2;
        r_rd        <= w_rd;
        r_imm       <= w_imm;
        r_use_imm   <= w_use_imm;
        r_reg_write <= w_reg_write;
        r_mem_read  <= w_mem_read;
        r_mem_write <= w_mem_write;
        r_branch    <= w_branch;
        r_jump      <= w_jump;
        r_illegal   <= w_illegal;
        r_ld_valid  <= w_mem_read;
        if (w_mem_read) r_ld_rd <= w_rd;
      end else begin
        r_out_valid <= 1'b0;
        r_use_imm   <= 1'b0;
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_branch    <= 1'b0;
        r_jump      <= 1'b0;
        r_illegal   <= 1'b0;
        r_ld_valid  <= 1'b0;
      end
    end
  end

  assign hz_stall  = w_hz;
  assign out_valid = r_out_valid;
  assign alu_op    = r_alu_op;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign rd        = r_rd;
  assign imm       = r_imm;
  assign use_imm   = r_use_imm;
  assign reg_write = r_reg_write;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign branch    = r_branch;
  assign jump      = r_jump;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_id_decode.sv
module tb_id_decode;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr;
  logic        stall;
  logic        flush;
  logic        hz_stall;
  logic        out_valid;
  logic [4:0]  alu_op;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        use_imm;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        jump;
  logic        illegal;

  id_decode dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .stall(stall), .flush(flush), .hz_stall(hz_stall), .out_valid(out_valid),
    .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .use_imm(use_imm), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .illegal(illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic loaded_edge = 1'b0;

  always @(posedge clk) begin
    cyc++;
    loaded_edge = !stall && !reset;
  end

  // Packed view: {alu_op, rs1, rs2, rd, imm, use_imm, reg_write, mem_read,
  //               mem_write, branch, jump, illegal}
  localparam int W = 59;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  function automatic logic [W-1:0] mk_exp(input logic [4:0] a, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [4:0] d,
                                          input logic [31:0] im, input logic [6:0] fl);
    return {a, s1, s2, d, im, fl};
  endfunction

  function automatic logic [W-1:0] obs();
    return {alu_op, rs1, rs2, rd, imm, use_imm, reg_write, mem_read,
            mem_write, branch, jump, illegal};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] s1, input logic [4:0] s2,
                                       input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s1, s2, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] s1,
                                       input logic [4:0] d, input logic [15:0] im);
    return {op, s1, d, im};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && loaded_edge && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got alu_op=%0d rd=%0d at cycle %0d, expected none",
                 alu_op, rd, cyc);
      end else begin
        logic [W-1:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if (obs() !== e || cyc != ec) begin
          failures++;
          $display("FAIL decode: got 0x%0h at cycle %0d, expected 0x%0h at cycle %0d",
                   obs(), cyc, e, ec);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Presents one instruction and holds it across hazard cycles. The expected
  // record is queued just before the edge that captures it.
  task automatic send(input logic [31:0] ins, input logic [W-1:0] e, input int exp_hz);
    int hz_cnt = 0;
    bit done = 0;
    @(negedge clk);
    in_valid = 1'b1;
    instr    = ins;
    for (int g = 0; g < 8; g++) begin
      #1;
      if (!hz_stall) begin
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 1);
        @(posedge clk);
        done = 1;
        break;
      end
      hz_cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL hz_timeout: hz_stall still high after 8 cycles, expected release");
    end
    check("hz_cycles", 64'(hz_cnt), 64'(exp_hz));
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    instr    = 32'h0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    instr    = 32'h0;
    stall    = 1'b0;
    flush    = 1'b0;

    #3;
    check("reset_outputs", {5'd0, out_valid, hz_stall, obs()}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ADD r3,r1,r2
    send(32'h00221820, mk_exp(5'd1, 5'd1, 5'd2, 5'd3, 32'h0, 7'b0100000), 0);
    // ANDI r4,r5,0xFFFF and ADDI r4,r5,0xFFFF
    send(mk_i(6'h0C, 5'd5, 5'd4, 16'hFFFF),
         mk_exp(5'd3, 5'd5, 5'd0, 5'd4, 32'h0000FFFF, 7'b1100000), 0);
    send(mk_i(6'h08, 5'd5, 5'd4, 16'hFFFF),
         mk_exp(5'd1, 5'd5, 5'd0, 5'd4, 32'hFFFFFFFF, 7'b1100000), 0);
    // SRA r11,r9,r10 and ADD r0,r1,r2 (write to r0 suppressed)
    send(mk_r(5'd9, 5'd10, 5'd11, 6'h07),
         mk_exp(5'd14, 5'd9, 5'd10, 5'd11, 32'h0, 7'b0100000), 0);
    send(mk_r(5'd1, 5'd2, 5'd0, 6'h20),
         mk_exp(5'd1, 5'd1, 5'd2, 5'd0, 32'h0, 7'b0000000), 0);

    // LW r7,0(r1) then ADD r8,r7,r2: one hazard cycle, bubble, then ADD
    send(mk_i(6'h23, 5'd1, 5'd7, 16'h0000),
         mk_exp(5'd1, 5'd1, 5'd0, 5'd7, 32'h0, 7'b1110000), 0);
    send(mk_r(5'd7, 5'd2, 5'd8, 6'h20),
         mk_exp(5'd1, 5'd7, 5'd2, 5'd8, 32'h0, 7'b0100000), 1);
    // LW r7 then SW r7,4(r3): hazard through rs2
    send(mk_i(6'h23, 5'd1, 5'd7, 16'h0000),
         mk_exp(5'd1, 5'd1, 5'd0, 5'd7, 32'h0, 7'b1110000), 0);
    send(mk_i(6'h2B, 5'd3, 5'd7, 16'h0004),
         mk_exp(5'd1, 5'd3, 5'd7, 5'd0, 32'h4, 7'b1001000), 1);
    // LW r7 then ADDI r9,r3,-1: independent, no hazard
    send(mk_i(6'h23, 5'd1, 5'd7, 16'h0000),
         mk_exp(5'd1, 5'd1, 5'd0, 5'd7, 32'h0, 7'b1110000), 0);
    send(mk_i(6'h08, 5'd3, 5'd9, 16'hFFFF),
         mk_exp(5'd1, 5'd3, 5'd0, 5'd9, 32'hFFFFFFFF, 7'b1100000), 0);

    // JAL 0x3FFFFFC, BEQZ r4,-8, opcode 0x3F, R-type func 0x01
    send({6'h03, 26'h3FFFFFC},
         mk_exp(5'd15, 5'd0, 5'd0, 5'd31, 32'hFFFFFFFC, 7'b1100010), 0);
    send(mk_i(6'h04, 5'd4, 5'd0, 16'hFFF8),
         mk_exp(5'd16, 5'd4, 5'd0, 5'd0, 32'hFFFFFFF8, 7'b1000100), 0);
    send(32'hFC000000, mk_exp(5'd1, 5'd0, 5'd0, 5'd0, 32'h0, 7'b0000001), 0);
    send(32'h00000001, mk_exp(5'd1, 5'd0, 5'd0, 5'd0, 32'h0, 7'b0000001), 0);

    // in_valid=0 gives an empty slot
    send(32'h00221820, mk_exp(5'd1, 5'd1, 5'd2, 5'd3, 32'h0, 7'b0100000), 0);
    idle();
    @(posedge clk);
    @(negedge clk);
    #1;
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // ORI r6,r2,0x8001, then stall three cycles with XORI presented
    send(mk_i(6'h0D, 5'd2, 5'd6, 16'h8001),
         mk_exp(5'd4, 5'd2, 5'd0, 5'd6, 32'h00008001, 7'b1100000), 0);
    @(negedge clk);
    stall    = 1'b1;
    in_valid = 1'b1;
    instr    = mk_i(6'h0E, 5'd1, 5'd9, 16'h1234);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      check("stall_hold", {4'd0, out_valid, obs()},
            {4'd0, 1'b1, mk_exp(5'd4, 5'd2, 5'd0, 5'd6, 32'h00008001, 7'b1100000)});
    end
    stall = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_reg_write", 64'(reg_write), 64'd0);
    flush    = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset mid-hazard: LW r7, then dependent ADD presented
    send(mk_i(6'h23, 5'd1, 5'd7, 16'h0000),
         mk_exp(5'd1, 5'd1, 5'd0, 5'd7, 32'h0, 7'b1110000), 0);
    @(negedge clk);
    in_valid = 1'b1;
    instr    = mk_r(5'd7, 5'd2, 5'd8, 6'h20);
    #1;
    check("pre_reset_hz", {62'd0, out_valid, hz_stall}, 64'd3);
    reset = 1'b1;
    #1;
    check("async_reset", {5'd0, out_valid, hz_stall, obs()}, 64'h0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
